// File: rtl/gray_packer.sv
// Gray-to-RGB565 expander: reads gray bytes from RWM_2 under a 2-credit scheme,
// buffers them in a 2-entry FIFO and streams RGB565 words over valid/ready.
module gray_packer #(
  parameter int N     = 1280,
  parameter int M     = 720,
  parameter int CNT_W = $clog2(N*M+1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        GP_enable,
  output logic        rd_req,
  input  logic [7:0]  Din,
  input  logic        Din_valid,
  output logic [15:0] Dout,
  output logic        Dout_valid,
  input  logic        Dout_ready,
  output logic        GP_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(N*M);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N*M-1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt, out_cnt;
  logic [1:0][7:0]  fifo_q;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ;
  logic             inflight;
  logic             active, abort, push, pop;
  logic [1:0]       occ_eff;
  logic [7:0]       head;

  assign active     = (state_q == RUN) || (state_q == FLUSH);
  assign abort      = active && !GP_enable;
  assign Dout_valid = (occ != 2'd0);
  assign pop        = Dout_valid && Dout_ready;
  // A byte landing on a full FIFO is a protocol error and is dropped.
  assign push       = Din_valid && active && (occ != 2'd2);

  // Credit check uses occupancy net of this cycle's pop so a word can be
  // replaced every cycle; occ + inflight never exceeds 2, so no overflow.
  assign occ_eff = occ - {1'b0, pop};
  assign rd_req  = (state_q == RUN) && GP_enable && (rd_cnt < TOTAL) &&
                   ((occ_eff + {1'b0, inflight}) < 2'd2);

  assign head    = fifo_q[rd_ptr];
  assign Dout    = Dout_valid ? {head[7:3], head[7:2], head[7:3]} : 16'h0000;
  assign GP_done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (GP_enable) state_d = RUN;
      RUN:     if (!GP_enable)           state_d = IDLE;
               else if (rd_cnt == TOTAL) state_d = FLUSH;
      // Going on the last handshake makes GP_done land one cycle after it.
      FLUSH:   if (!GP_enable) state_d = IDLE;
               else if ((out_cnt == TOTAL) || (pop && (out_cnt == LAST))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      out_cnt  <= '0;
      fifo_q   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else if (!active || abort) begin
      // Outside a frame (and on abort) everything is cleared, so a late
      // Din_valid is discarded and the next frame starts from pixel 0.
      rd_cnt   <= '0;
      out_cnt  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_req;
      if (rd_req && (rd_cnt != TOTAL)) rd_cnt <= rd_cnt + 1'b1;
      if (pop && (out_cnt != TOTAL))   out_cnt <= out_cnt + 1'b1;
      if (push) begin
        fifo_q[wr_ptr] <= Din;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_gray_packer.sv
// Directed bench for gray_packer on a 4x2 frame: latency, stall, random
// backpressure, abort and mid-frame reset, with a 1-cycle memory model.
module tb_gray_packer;

  localparam int N = 4;
  localparam int M = 2;
  localparam int NW = N*M;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        GP_enable;
  logic        rd_req;
  logic [7:0]  Din = 8'h00;
  logic        Din_valid = 1'b0;
  logic [15:0] Dout;
  logic        Dout_valid;
  logic        Dout_ready;
  logic        GP_done;

  gray_packer #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .GP_enable(GP_enable), .rd_req(rd_req),
    .Din(Din), .Din_valid(Din_valid), .Dout(Dout), .Dout_valid(Dout_valid),
    .Dout_ready(Dout_ready), .GP_done(GP_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  tbl [8] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hF8, 8'h55, 8'hAA};
  localparam logic [15:0] EXP [8] = '{16'h0000, 16'hFFFF, 16'h8410, 16'h7BEF,
                                     16'h0000, 16'hFFDF, 16'h52AA, 16'hAD55};

  // Memory model: byte returned one cycle after its read strobe.
  logic       mem_clr = 1'b1;
  logic [2:0] rd_addr = 3'd0;
  always @(posedge clk) begin
    Din_valid <= rd_req;
    if (mem_clr) rd_addr <= 3'd0;
    else if (rd_req) begin
      Din     <= tbl[rd_addr];
      rd_addr <= rd_addr + 3'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] got [$];
  int done_cnt = 0, req_cnt = 0, first_req_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (Dout_valid && Dout_ready) begin
        got.push_back(Dout);
        last_hs_cyc <= cyc;
      end
      if (GP_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (rd_req) begin
        req_cnt <= req_cnt + 1;
        if (first_req_cyc < 0) first_req_cyc <= cyc;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 200) begin tick(); k++; end
    chk(tag, got.size(), n);
  endtask

  task automatic wait_done(input int d, input string tag);
    int k = 0;
    while (done_cnt < d && k < 300) begin tick(); k++; end
    chk(tag, done_cnt, d);
  endtask

  task automatic chk_frame(input int base, input string tag);
    for (int i = 0; i < NW; i++) chk(tag, got[base+i], EXP[i]);
  endtask

  task automatic mem_reset();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  initial begin
    int b, r0, d0;
    rst_n = 1'b0; GP_enable = 1'b0; Dout_ready = 1'b0;
    tick(); tick();
    chk("rst dout_valid", Dout_valid, 0);
    chk("rst rd_req", rd_req, 0);
    chk("rst done", GP_done, 0);
    chk("rst dout", Dout, 0);
    rst_n = 1'b1;
    mem_reset();

    // 1: plain frame, latency and done timing
    b = got.size(); r0 = req_cnt;
    Dout_ready = 1'b1; GP_enable = 1'b1;
    chk("t1 idle no req", rd_req, 0);
    tick();
    chk("t1 first req", rd_req, 1);
    tick();
    chk("t1 no valid yet", Dout_valid, 0);
    tick();
    chk("t1 first valid", Dout_valid, 1);
    chk("t1 first word", Dout, 16'h0000);
    wait_done(1, "t1 done");
    GP_enable = 1'b0;
    chk("t1 words", got.size() - b, NW);
    chk_frame(b, "t1 word");
    chk("t1 reqs", req_cnt - r0, NW);
    chk("t1 done after last hs", done_cyc - last_hs_cyc, 1);
    chk("t1 frame cycles", done_cyc - first_req_cyc, NW + 2);
    tick();
    chk("t1 idle done low", GP_done, 0);
    mem_reset();

    // 2: 10-cycle stall after the 3rd word
    b = got.size(); d0 = done_cnt;
    Dout_ready = 1'b1; GP_enable = 1'b1;
    wait_words(b + 3, "t2 pre-stall");
    Dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t2 stall dout", Dout, 16'h7BEF);
      chk("t2 stall valid", Dout_valid, 1);
      if (i >= 3) chk("t2 stall no req", rd_req, 0);
      tick();
    end
    Dout_ready = 1'b1;
    wait_done(d0 + 1, "t2 done");
    GP_enable = 1'b0;
    chk("t2 words", got.size() - b, NW);
    chk_frame(b, "t2 word");
    mem_reset();

    // 3: random backpressure
    b = got.size(); r0 = req_cnt; d0 = done_cnt;
    GP_enable = 1'b1;
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      Dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    GP_enable = 1'b0; Dout_ready = 1'b1;
    repeat (5) tick();
    chk("t3 words", got.size() - b, NW);
    chk_frame(b, "t3 word");
    chk("t3 reqs", req_cnt - r0, NW);
    chk("t3 done once", done_cnt - d0, 1);
    mem_reset();

    // 4: abort after the 3rd handshake, then a fresh frame
    b = got.size(); d0 = done_cnt;
    Dout_ready = 1'b1; GP_enable = 1'b1;
    wait_words(b + 3, "t4 pre-abort");
    GP_enable = 1'b0; Dout_ready = 1'b0;
    tick();
    chk("t4 abort valid", Dout_valid, 0);
    chk("t4 abort req", rd_req, 0);
    repeat (4) tick();
    chk("t4 no done", done_cnt, d0);
    mem_reset();
    b = got.size(); r0 = req_cnt;
    Dout_ready = 1'b1; GP_enable = 1'b1;
    wait_done(d0 + 1, "t4 refr done");
    GP_enable = 1'b0;
    chk("t4 refr words", got.size() - b, NW);
    chk_frame(b, "t4 refr word");
    chk("t4 refr reqs", req_cnt - r0, NW);
    mem_reset();

    // 5: reset mid-frame with data buffered
    d0 = done_cnt;
    Dout_ready = 1'b0; GP_enable = 1'b1;
    repeat (4) tick();
    chk("t5 pre valid", Dout_valid, 1);
    rst_n = 1'b0; GP_enable = 1'b0;
    #1;
    chk("t5 rst valid", Dout_valid, 0);
    chk("t5 rst dout", Dout, 0);
    chk("t5 rst req", rd_req, 0);
    chk("t5 rst done", GP_done, 0);
    tick();
    rst_n = 1'b1;
    mem_reset();
    chk("t5 no done", done_cnt, d0);
    b = got.size();
    Dout_ready = 1'b1; GP_enable = 1'b1;
    wait_done(d0 + 1, "t5 clean done");
    GP_enable = 1'b0;
    chk("t5 clean words", got.size() - b, NW);
    chk_frame(b, "t5 clean word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
